// File: rtl/xor_line_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xor_line_pkg
//  Description : Shared definitions for the XOR differential line encoder and
//                receiver: framer state encoding, start/stop bit polarity and
//                the even-parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package xor_line_pkg;

    // Framer states. The encoding is explicit so both the transmitter and the
    // receiver agree on it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } line_state_t;

    // An idle line decodes to 0, so a frame opens with a decoded 1 and
    // closes with a decoded 0.
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    // Widest data field either side of the link supports.
    localparam int MAX_WIDTH = 16;

    // Even-parity bit for a data field: the value that makes the total count
    // of ones across data plus parity even. Narrower fields are passed in
    // zero-extended, which leaves the result unchanged.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage : xor_line_pkg
`default_nettype wire

// File: rtl/xor_diff_decode.sv
`default_nettype none
// ============================================================================
//  Module      : xor_diff_decode
//  Description : XOR differential line decoder. Keeps the previously sampled
//                line bit and produces b[n] = e[n] ^ e[n-1] for every strobed
//                line sample.
//  Ports       : clk        rising-edge clock
//                reset      synchronous active-high reset (prev line bit -> 0)
//                in_valid   line sample strobe
//                in_bit     encoded line bit e[n]
//                dec_valid  decoded bit strobe (same cycle as in_valid)
//                dec_bit    decoded bit b[n]
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_diff_decode (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_bit,
    output logic dec_valid,
    output logic dec_bit
);

    logic r_prev_e;

    // The previous line bit only moves on a strobe; unstrobed cycles leave
    // the decoder history untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_e <= 1'b0;
        end else if (in_valid) begin
            r_prev_e <= in_bit;
        end
    end

    // The decoded bit is combinational so the framer consumes it on the same
    // edge that samples the line bit.
    assign dec_valid = in_valid;
    assign dec_bit   = in_bit ^ r_prev_e;

endmodule : xor_diff_decode
`default_nettype wire

// File: rtl/xor_diff_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : xor_diff_frame_rx
//  Description : Receive side of the XOR differential serial link. Decodes
//                the line, frames decoded bits as
//                  start(1) | WIDTH data bits LSB first | even parity | stop(0)
//                and hands complete words downstream through a one-entry
//                valid/ready output buffer.
//  Parameters  : WIDTH      data bits per frame (1..16)
//  Ports       : clk        rising-edge clock
//                reset      synchronous active-high reset
//                in_valid   line sample strobe
//                in_bit     encoded line bit
//                out_data   received word, LSB = first data bit
//                out_valid  out_data / out_perr hold a word
//                out_ready  consumer accepts the word when out_valid is high
//                out_perr   parity mismatch for the held word
//                frame_err  one-cycle pulse: stop bit was not 0
//                overrun    one-cycle pulse: good frame dropped, buffer full
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_diff_frame_rx
    import xor_line_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr,
    output logic             frame_err,
    output logic             overrun
);

    // Data-bit counter runs 0..WIDTH-1; one bit is enough for WIDTH = 1.
    localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Line decoder
    // ------------------------------------------------------------------
    logic w_dec_valid;
    logic w_dec_bit;

    xor_diff_decode u_decode (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .dec_valid (w_dec_valid),
        .dec_bit   (w_dec_bit)
    );

    // ------------------------------------------------------------------
    // Framer state
    // ------------------------------------------------------------------
    line_state_t          r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_shift;
    logic                 r_perr;
    logic                 r_frame_err;

    // Output buffer state
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_valid;
    logic                 r_out_perr;
    logic                 r_overrun;

    logic [WIDTH-1:0]     w_shift_next;
    logic [MAX_WIDTH-1:0] w_par_vec;
    logic                 w_data_par;
    logic                 w_stop_strobe;
    logic                 w_good;
    logic                 w_bad;
    logic                 w_consume;
    logic                 w_load;

    always_comb begin
        // New bits enter at the MSB side so that after WIDTH shifts the first
        // data bit received sits at bit 0.
        w_shift_next             = r_shift >> 1;
        w_shift_next[WIDTH-1]    = w_dec_bit;

        // The parity helper works on the widest field; zero padding does not
        // change the parity of the real data bits.
        w_par_vec                = '0;
        w_par_vec[WIDTH-1:0]     = r_shift;
        w_data_par               = even_parity(w_par_vec);
    end

    // Stop-bit strobe: the frame is decided on this edge.
    assign w_stop_strobe = w_dec_valid && (r_state == STOP);
    assign w_good        = w_stop_strobe && (w_dec_bit == STOP_BIT);
    assign w_bad         = w_stop_strobe && (w_dec_bit != STOP_BIT);

    // The buffer can take a new word when it is empty or when its current
    // word leaves on this very edge (back-to-back, no bubble).
    assign w_consume     = r_out_valid && out_ready;
    assign w_load        = w_good && (!r_out_valid || out_ready);

    // ------------------------------------------------------------------
    // Framer FSM. Advances only on decoded-bit strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_perr      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad;

            if (w_dec_valid) begin
                case (r_state)
                    IDLE: begin
                        if (w_dec_bit == START_BIT) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                        end
                    end

                    DATA: begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + c_cnt_w'(1);
                        if (r_cnt == c_last_cnt) begin
                            r_state <= PARITY;
                        end
                    end

                    PARITY: begin
                        // Mismatch when the received parity bit differs from
                        // the even-parity bit of the collected data.
                        r_perr  <= w_data_par ^ w_dec_bit;
                        r_state <= STOP;
                    end

                    STOP: begin
                        // Good or bad, the stop bit always ends the frame;
                        // a bad stop is not reinterpreted as a start bit.
                        r_state <= IDLE;
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // One-entry output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // A good frame that cannot be loaded is dropped; the held word
            // is left untouched.
            r_overrun <= w_good && !w_load;

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_shift;
                r_out_perr  <= r_perr;
            end else if (w_consume) begin
                // out_data keeps its last value once the word is gone.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_perr  = r_out_perr;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule : xor_diff_frame_rx
`default_nettype wire

// File: tb/tb_xor_diff_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xor_diff_frame_rx
//  Description : Self-checking bench for xor_diff_frame_rx. Frames are built
//                from their decoded bit list, XOR-encoded onto the line by the
//                bench and compared every cycle against a word-level model of
//                the one-entry output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_diff_frame_rx;

    localparam int WIDTH    = 8;
    localparam int EV_NONE  = 0;  // no frame ends on this strobe
    localparam int EV_GOOD  = 1;  // good stop bit on this strobe
    localparam int EV_BAD   = 2;  // bad stop bit on this strobe

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_bit;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_perr;
    logic             frame_err;
    logic             overrun;

    int n_checks = 0;
    int n_pass   = 0;
    string phase = "init";

    // Bench line state (last encoded bit driven) and buffer model.
    logic             line_e;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_perr;
    logic             exp_ferr;
    logic             exp_ovr;

    xor_diff_frame_rx #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_perr  (out_perr),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    endtask

    function automatic logic pick_rdy(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return (mode == 1);
    endfunction

    // One clock: drive inputs, advance the model on the edge, compare #1 later.
    task automatic tick(input logic v, input logic b, input logic rdy, input int ev,
                        input logic [WIDTH-1:0] word, input logic perr);
        in_valid  = v;
        in_bit    = b;
        out_ready = rdy;
        @(posedge clk);
        exp_ferr = (ev == EV_BAD);
        exp_ovr  = 1'b0;
        if (ev == EV_GOOD) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_data  = word;
                m_perr  = perr;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        check("overrun",   32'(overrun),   32'(exp_ovr));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_perr", 32'(out_perr), 32'(m_perr));
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'($urandom_range(0, 1));
        in_bit    = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        line_e  = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_perr",  32'(out_perr),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        reset = 1'b0;
    endtask

    // Idle strobes: line bit repeated, so each decodes to 0.
    task automatic idle(input int n, input int rdy_mode);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, line_e, pick_rdy(rdy_mode), EV_NONE, '0, 1'b0);
        end
    endtask

    // Send one frame described at the decoded-bit level, with optional
    // unstrobed gap cycles (random line value) before each bit.
    task automatic send_frame(input logic [WIDTH-1:0] data, input logic flip_par,
                              input logic bad_stop, input int rdy_mode,
                              input int stop_rdy_mode, input int max_gap);
        logic bits[$];
        int   last;
        bits.push_back(1'b1);
        for (int i = 0; i < WIDTH; i++) bits.push_back(data[i]);
        bits.push_back((^data) ^ flip_par);
        bits.push_back(bad_stop);
        last = bits.size() - 1;
        for (int i = 0; i <= last; i++) begin
            repeat ($urandom_range(0, max_gap))
                tick(1'b0, 1'($urandom_range(0, 1)), pick_rdy(rdy_mode), EV_NONE, '0, 1'b0);
            line_e = line_e ^ bits[i];
            if (i == last)
                tick(1'b1, line_e, pick_rdy(stop_rdy_mode),
                     bad_stop ? EV_BAD : EV_GOOD, data, flip_par);
            else
                tick(1'b1, line_e, pick_rdy(rdy_mode), EV_NONE, '0, 1'b0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        line_e    = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_perr    = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;

        phase = "reset";
        do_reset();
        do_reset();

        phase = "idle20";
        idle(20, 1);

        phase = "a5";
        send_frame(8'hA5, 1'b0, 1'b0, 1, 1, 0);
        idle(3, 1);

        phase = "3c_perr";
        send_frame(8'h3C, 1'b1, 1'b0, 1, 1, 1);
        idle(3, 1);

        phase = "5a_ferr";
        send_frame(8'h5A, 1'b0, 1'b1, 1, 1, 1);
        idle(2, 1);
        phase = "01_after_ferr";
        send_frame(8'h01, 1'b0, 1'b0, 1, 1, 1);
        idle(3, 1);

        phase = "overrun";
        send_frame(8'h11, 1'b0, 1'b0, 0, 0, 1);
        send_frame(8'h22, 1'b0, 1'b0, 0, 0, 1);
        idle(2, 0);
        idle(3, 1);

        phase = "no_bubble";
        send_frame(8'h33, 1'b0, 1'b0, 0, 0, 0);
        send_frame(8'h44, 1'b1, 1'b0, 0, 1, 0);
        idle(3, 1);

        phase = "mid_reset";
        idle(2, 1);
        line_e = ~line_e;                      // start bit of 0xFF
        tick(1'b1, line_e, 1'b1, EV_NONE, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin      // four data ones
            line_e = ~line_e;
            tick(1'b1, line_e, 1'b1, EV_NONE, '0, 1'b0);
        end
        do_reset();
        send_frame(8'h81, 1'b0, 1'b0, 1, 1, 0);
        idle(2, 1);

        phase = "back_to_back";
        send_frame(8'h81, 1'b0, 1'b0, 1, 1, 0);
        send_frame(8'h7E, 1'b0, 1'b0, 1, 1, 0);
        idle(3, 1);

        phase = "random";
        for (int f = 0; f < 40; f++) begin
            send_frame(WIDTH'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) == 0), 2, 2, 2);
            idle(int'($urandom_range(0, 3)), 2);
        end
        idle(3, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_xor_diff_frame_rx
`default_nettype wire
